// File: rtl/pipe_stage_pkg.sv
// Shared types and helpers for the parametrised operand-sequencing pipe stage.
package pipe_stage_pkg;

   typedef enum logic [1:0] {
      MODE_SCALE = 2'd0,
      MODE_PAIR  = 2'd1,
      MODE_NORM  = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Maximum number of stages a load can run in the given mode.
   // PAIR mode consumes two lanes per stage.
   function automatic int stage_limit(mode_e m, int lanes);
      return (m == MODE_PAIR) ? lanes / 2 : lanes;
   endfunction

endpackage

// File: rtl/pipe_pair_sel.sv
// Combinational selection of the next (op1, op2) pair from the captured lanes.
module pipe_pair_sel
   import pipe_stage_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LANES  = 8,
   parameter int CNT_W  = $clog2(LANES + 1),
   parameter int POS_W  = $clog2(DATA_W)
) (
   input  logic [LANES-1:0][DATA_W-1:0] lanes_i,
   input  logic [DATA_W-1:0]            scale_i,
   input  logic [POS_W-1:0]             pos_i,
   input  mode_e                        mode_i,
   input  logic [CNT_W-1:0]             stage_i,
   output logic [DATA_W-1:0]            op1_o,
   output logic [DATA_W-1:0]            op2_o
);

   logic [CNT_W:0]      idx_a;
   logic [CNT_W:0]      idx_b;
   logic [DATA_W-1:0]   lane_a;
   logic [DATA_W-1:0]   lane_b;
   logic [DATA_W-1:0]   mask;

   // Pick lane(s) for this stage, then form the pair according to mode.
   // Out-of-range indices (never consumed by the parent) read as zero.
   always_comb begin
      idx_a  = (mode_i == MODE_PAIR) ? {stage_i, 1'b0} : {1'b0, stage_i};
      idx_b  = idx_a + (CNT_W+1)'(1);
      lane_a = '0;
      lane_b = '0;
      for (int k = 0; k < LANES; k++) begin
         if (idx_a == (CNT_W+1)'(k)) lane_a = lanes_i[k];
         if (idx_b == (CNT_W+1)'(k)) lane_b = lanes_i[k];
      end
      mask = ~({DATA_W{1'b1}} << pos_i);
      case (mode_i)
         MODE_PAIR: begin
            op1_o = lane_a;
            op2_o = lane_b;
         end
         MODE_NORM: begin
            op1_o = $unsigned($signed(lane_a) >>> pos_i);
            op2_o = lane_a & mask;
         end
         default: begin
            op1_o = lane_a;
            op2_o = scale_i;
         end
      endcase
   end

endmodule

// File: rtl/pipe_stage_param.sv
// Parametrised operand-sequencing pipe stage: captures LANES operands in one
// handshake and emits one registered operand pair per non-stalled cycle.
module pipe_stage_param
   import pipe_stage_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LANES  = 8,
   parameter int CNT_W  = $clog2(LANES + 1),
   parameter int POS_W  = $clog2(DATA_W)
) (
   input  logic                      CLK_i,
   input  logic                      RST_i,
   input  logic                      stall_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [LANES*DATA_W-1:0]   operand_i,
   input  logic [DATA_W-1:0]         scale_i,
   input  logic [CNT_W-1:0]          norm_n,
   input  logic [POS_W-1:0]          pos,
   input  logic [1:0]                mode,
   output logic                      out_valid_o,
   output logic [DATA_W-1:0]         operand1_o,
   output logic [DATA_W-1:0]         operand2_o,
   output logic [CNT_W-1:0]          stage_o,
   output logic                      stage_boundary_o,
   output logic                      finished_o,
   output logic                      busy_o,
   output logic                      mode_err_o
);

   logic [LANES-1:0][DATA_W-1:0] lanes_in;
   logic [LANES-1:0][DATA_W-1:0] lanes_d, lanes_q, sel_lanes;
   logic [DATA_W-1:0]            scale_d, scale_q, sel_scale;
   logic [POS_W-1:0]             pos_d, pos_q, sel_pos;
   mode_e                        mode_d, mode_q, sel_mode, mode_in_eff;
   logic [CNT_W-1:0]             n_d, n_q, n_in, lim, sel_stage, stage_nxt;
   state_e                       state_d, state_q;
   logic                         out_valid_d, out_valid_q;
   logic [DATA_W-1:0]            op1_d, op1_q, op2_d, op2_q, sel_op1, sel_op2;
   logic [CNT_W-1:0]             stage_d, stage_q;
   logic                         bnd_d, bnd_q;
   logic                         fin_d, fin_q;
   logic                         merr_d, merr_q;
   logic                         accept;

   assign lanes_in = operand_i;

   // On the accept cycle the selector works on the live inputs so pair 0 is
   // registered at the same edge the load is captured.
   always_comb begin
      accept      = (state_q == ST_IDLE) & ~stall_i & valid_i;
      mode_in_eff = (mode_e'(mode) == MODE_RSVD) ? MODE_SCALE : mode_e'(mode);
      lim         = CNT_W'(stage_limit(mode_in_eff, LANES));
      n_in        = (norm_n > lim) ? lim : norm_n;
      stage_nxt   = stage_q + CNT_W'(1);
      sel_lanes   = accept ? lanes_in    : lanes_q;
      sel_scale   = accept ? scale_i     : scale_q;
      sel_pos     = accept ? pos         : pos_q;
      sel_mode    = accept ? mode_in_eff : mode_q;
      sel_stage   = accept ? '0          : stage_nxt;
   end

   pipe_pair_sel #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .CNT_W  (CNT_W),
      .POS_W  (POS_W)
   ) u_sel (
      .lanes_i (sel_lanes),
      .scale_i (sel_scale),
      .pos_i   (sel_pos),
      .mode_i  (sel_mode),
      .stage_i (sel_stage),
      .op1_o   (sel_op1),
      .op2_o   (sel_op2)
   );

   // Next-state: everything holds under stall; stage_q doubles as the counter.
   always_comb begin
      lanes_d     = lanes_q;
      scale_d     = scale_q;
      pos_d       = pos_q;
      mode_d      = mode_q;
      n_d         = n_q;
      state_d     = state_q;
      out_valid_d = out_valid_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      stage_d     = stage_q;
      bnd_d       = bnd_q;
      fin_d       = fin_q;
      merr_d      = merr_q;
      if (!stall_i) begin
         case (state_q)
            ST_IDLE: begin
               if (valid_i) begin
                  lanes_d = lanes_in;
                  scale_d = scale_i;
                  pos_d   = pos;
                  mode_d  = mode_in_eff;
                  n_d     = n_in;
                  merr_d  = merr_q | (mode == 2'd3);
                  if (n_in == '0) begin
                     state_d = ST_DONE;
                     fin_d   = 1'b1;
                  end else begin
                     state_d     = ST_RUN;
                     out_valid_d = 1'b1;
                     op1_d       = sel_op1;
                     op2_d       = sel_op2;
                     stage_d     = '0;
                     bnd_d       = (n_in == CNT_W'(1));
                  end
               end
            end
            ST_RUN: begin
               if (stage_q == n_q - CNT_W'(1)) begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b0;
                  bnd_d       = 1'b0;
                  fin_d       = 1'b1;
               end else begin
                  op1_d   = sel_op1;
                  op2_d   = sel_op2;
                  stage_d = stage_nxt;
                  bnd_d   = (stage_nxt == n_q - CNT_W'(1));
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               fin_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers; reset abandons any load in flight.
   always_ff @(posedge CLK_i or negedge RST_i) begin
      if (!RST_i) begin
         lanes_q     <= '0;
         scale_q     <= '0;
         pos_q       <= '0;
         mode_q      <= MODE_SCALE;
         n_q         <= '0;
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         stage_q     <= '0;
         bnd_q       <= 1'b0;
         fin_q       <= 1'b0;
         merr_q      <= 1'b0;
      end else begin
         lanes_q     <= lanes_d;
         scale_q     <= scale_d;
         pos_q       <= pos_d;
         mode_q      <= mode_d;
         n_q         <= n_d;
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         stage_q     <= stage_d;
         bnd_q       <= bnd_d;
         fin_q       <= fin_d;
         merr_q      <= merr_d;
      end
   end

   assign ready_o          = (state_q == ST_IDLE) & ~stall_i;
   assign busy_o           = (state_q != ST_IDLE);
   assign out_valid_o      = out_valid_q;
   assign operand1_o       = op1_q;
   assign operand2_o       = op2_q;
   assign stage_o          = stage_q;
   assign stage_boundary_o = bnd_q;
   assign finished_o       = fin_q;
   assign mode_err_o       = merr_q;

endmodule

// File: tb/tb_pipe_stage_param.sv
// Randomised + directed bench for pipe_stage_param against a queue-based model.
module tb_pipe_stage_param;

   localparam int DATA_W = 16;
   localparam int LANES  = 8;
   localparam int CNT_W  = $clog2(LANES + 1);
   localparam int POS_W  = $clog2(DATA_W);

   logic                    CLK_i = 1'b0;
   logic                    RST_i = 1'b0;
   logic                    stall_i = 1'b0;
   logic                    valid_i = 1'b0;
   logic                    ready_o;
   logic [LANES*DATA_W-1:0] operand_i = '0;
   logic [DATA_W-1:0]       scale_i = '0;
   logic [CNT_W-1:0]        norm_n = '0;
   logic [POS_W-1:0]        pos = '0;
   logic [1:0]              mode = '0;
   logic                    out_valid_o;
   logic [DATA_W-1:0]       operand1_o, operand2_o;
   logic [CNT_W-1:0]        stage_o;
   logic                    stage_boundary_o, finished_o, busy_o, mode_err_o;

   pipe_stage_param #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .CLK_i(CLK_i), .RST_i(RST_i), .stall_i(stall_i), .valid_i(valid_i),
      .ready_o(ready_o), .operand_i(operand_i), .scale_i(scale_i),
      .norm_n(norm_n), .pos(pos), .mode(mode), .out_valid_o(out_valid_o),
      .operand1_o(operand1_o), .operand2_o(operand2_o), .stage_o(stage_o),
      .stage_boundary_o(stage_boundary_o), .finished_o(finished_o),
      .busy_o(busy_o), .mode_err_o(mode_err_o)
   );

   always #5 CLK_i = ~CLK_i;

   // Expected observation sequence of one load: pairs, then a finished marker.
   typedef struct {
      logic [15:0] op1;
      logic [15:0] op2;
      int          stage;
      bit          bnd;
      bit          done;
   } ev_t;

   ev_t         evq[$];
   bit          m_idle = 1'b1;
   bit          m_valid, m_bnd, m_fin, m_merr;
   logic [15:0] m_op1, m_op2;
   int          m_stage;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] ln[LANES];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic pack_lanes();
      for (int k = 0; k < LANES; k++) operand_i[k*DATA_W +: DATA_W] = ln[k];
   endtask

   // Expand a load into its expected pairs directly from the mode rules.
   task automatic model_load();
      int eff, lim, n, v, rem, div;
      logic [15:0] a, b;
      eff = (mode == 2'd3) ? 0 : int'(mode);
      lim = (eff == 1) ? LANES / 2 : LANES;
      n   = (int'(norm_n) < lim) ? int'(norm_n) : lim;
      if (mode == 2'd3) m_merr = 1'b1;
      for (int s = 0; s < n; s++) begin
         ev_t e;
         if (eff == 1) begin
            a = operand_i[(2*s)*DATA_W +: DATA_W];
            b = operand_i[(2*s+1)*DATA_W +: DATA_W];
         end else if (eff == 2) begin
            a   = operand_i[s*DATA_W +: DATA_W];
            div = 1 << pos;
            rem = int'(a) % div;
            v   = int'($signed(a));
            b   = 16'(rem);
            a   = 16'((v - rem) / div);
         end else begin
            a = operand_i[s*DATA_W +: DATA_W];
            b = scale_i;
         end
         e.op1 = a; e.op2 = b; e.stage = s; e.bnd = (s == n - 1); e.done = 1'b0;
         evq.push_back(e);
      end
      begin
         ev_t d;
         d.op1 = '0; d.op2 = '0; d.stage = 0; d.bnd = 1'b0; d.done = 1'b1;
         evq.push_back(d);
      end
   endtask

   task automatic model_reset();
      evq.delete();
      m_idle = 1'b1; m_valid = 1'b0; m_bnd = 1'b0; m_fin = 1'b0; m_merr = 1'b0;
      m_op1 = '0; m_op2 = '0; m_stage = 0;
   endtask

   task automatic check_outputs();
      check("out_valid", out_valid_o, m_valid);
      check("operand1", operand1_o, m_op1);
      check("operand2", operand2_o, m_op2);
      check("stage", stage_o, m_stage);
      check("boundary", stage_boundary_o, m_bnd);
      check("finished", finished_o, m_fin);
      check("busy", busy_o, !m_idle);
      check("mode_err", mode_err_o, m_merr);
   endtask

   // One clock: check ready, clock, advance model, compare all outputs.
   task automatic tick();
      bit st, acc;
      #1;
      check("ready", ready_o, m_idle && !stall_i);
      st  = stall_i;
      acc = m_idle && !st && valid_i;
      if (acc) model_load();
      @(posedge CLK_i);
      #1;
      if (!st && (acc || !m_idle)) begin
         m_idle = 1'b0;
         if (evq.size() == 0) begin
            m_idle = 1'b1; m_valid = 1'b0; m_fin = 1'b0; m_bnd = 1'b0;
         end else begin
            ev_t e;
            e = evq.pop_front();
            if (e.done) begin
               m_valid = 1'b0; m_bnd = 1'b0; m_fin = 1'b1;
            end else begin
               m_valid = 1'b1; m_op1 = e.op1; m_op2 = e.op2;
               m_stage = e.stage; m_bnd = e.bnd; m_fin = 1'b0;
            end
         end
      end
      check_outputs();
   endtask

   task automatic do_reset();
      @(posedge CLK_i);
      #2 RST_i = 1'b0;
      #1 model_reset();
      check_outputs();
      check("ready_in_reset", ready_o, !stall_i);
      @(posedge CLK_i);
      #2 RST_i = 1'b1;
   endtask

   // Issue a load and run it to completion; stall_pct gives random stalls,
   // st_at/st_len a directed stall window (cycle index after accept).
   task automatic run_load(input logic [1:0] md, input int nn, input int p,
                           input logic [15:0] sc, input int stall_pct,
                           input int st_at, input int st_len);
      int c;
      pack_lanes();
      mode = md; norm_n = CNT_W'(nn); pos = POS_W'(p); scale_i = sc;
      stall_i = 1'b0; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      c = 1;
      while (!m_idle && c < 200) begin
         stall_i = (c >= st_at && c < st_at + st_len) ||
                   ($urandom_range(99) < stall_pct);
         valid_i = 1'($urandom_range(1));
         operand_i = {$urandom, $urandom, $urandom, $urandom};
         tick();
         c++;
      end
      check("run_timeout", 32'(m_idle), 32'd1);
      stall_i = 1'b0; valid_i = 1'b0;
   endtask

   initial begin
      model_reset();
      #1 check_outputs();
      check("ready_reset", ready_o, 1'b1);
      @(posedge CLK_i);
      #2 RST_i = 1'b1;

      // SCALE, lanes 1..8, scale 3, n=8
      for (int k = 0; k < LANES; k++) ln[k] = 16'(k + 1);
      run_load(2'd0, 8, 0, 16'h0003, 0, 0, 0);
      // PAIR, norm_n=7 clamps to 4
      run_load(2'd1, 7, 0, 16'h0000, 0, 0, 0);
      // NORM, lane0=-123, pos=4, n=1
      ln[0] = 16'hFF85;
      pack_lanes();
      mode = 2'd2; norm_n = CNT_W'(1); pos = POS_W'(4); valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      check("norm_op1", operand1_o, 16'hFFF8);
      check("norm_op2", operand2_o, 16'h0005);
      check("norm_bnd", stage_boundary_o, 1'b1);
      tick(); tick();
      // SCALE n=4 with 3-cycle stall while pair 2 is shown
      for (int k = 0; k < LANES; k++) ln[k] = 16'(16'h10 + k);
      run_load(2'd0, 4, 0, 16'h0007, 0, 3, 3);
      // n=0: finished only
      run_load(2'd0, 0, 0, 16'h0001, 0, 0, 0);
      // reserved mode, then a clean load: error stays sticky
      run_load(2'd3, 3, 0, 16'h0009, 0, 0, 0);
      run_load(2'd1, 2, 0, 16'h0000, 0, 0, 0);
      check("merr_sticky", mode_err_o, 1'b1);
      // stall while idle blocks a load request
      stall_i = 1'b1; valid_i = 1'b1;
      tick(); tick();
      stall_i = 1'b0; valid_i = 1'b0;
      // reset mid-run after pair 1
      pack_lanes();
      mode = 2'd0; norm_n = CNT_W'(6); scale_i = 16'h0042; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      tick();
      do_reset();
      tick(); tick();

      // randomized loads
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < LANES; k++) ln[k] = 16'($urandom);
         run_load(2'($urandom_range(3)), $urandom_range(LANES), $urandom_range(DATA_W - 1),
                  16'($urandom), 25, 0, 0);
         if ($urandom_range(3) == 0) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_param.md
Name: pipe_stage_param

Overview:
- Parametrised successor of the fixed operand-sequencing pipe stage that feeds the reconfigurable tile.
- Captures a vector of LANES operands plus scale, stage count and shift position in one handshake.
- Emits one registered (operand1, operand2) pair per non-stalled cycle, in one of three selectable modes.
- Flags the last stage and signals completion to the tile controller.

Parameters:
- DATA_W, 16, operand/scale width in bits (signed two's complement)
- LANES, 8, operands captured per load (even, >=2)
- CNT_W, $clog2(LANES+1), width of norm_n and stage_o
- POS_W, $clog2(DATA_W), width of pos

Ports:
- CLK_i  in  1  clock, rising edge
- RST_i  in  1  reset, asynchronous assert, active-low
- stall_i  in  1  freeze all state and outputs
- valid_i  in  1  load request
- ready_o  out  1  load accepted when valid_i & ready_o
- operand_i  in  LANES*DATA_W  operand vector; lane k = bits [k*DATA_W +: DATA_W]
- scale_i  in  DATA_W  scale value (MODE_SCALE)
- norm_n  in  CNT_W  stages to run
- pos  in  POS_W  shift position (MODE_NORM)
- mode  in  2  0=SCALE, 1=PAIR, 2=NORM, 3=reserved
- out_valid_o  out  1  operand pair valid this cycle
- operand1_o  out  DATA_W  first operand
- operand2_o  out  DATA_W  second operand
- stage_o  out  CNT_W  stage index of current pair
- stage_boundary_o  out  1  high with the last pair of a load
- finished_o  out  1  load complete
- busy_o  out  1  state != IDLE
- mode_err_o  out  1  sticky; set on load with mode=3

Behaviour:
- Reset (RST_i=0, asynchronous): state IDLE; all outputs and registers 0, except ready_o=1 when stall_i=0.
- Reset mid-run: the load is abandoned and no finished_o is issued.
- ready_o = (state==IDLE) & !stall_i. Accept cycle t registers operand_i, scale_i, pos and mode.
- Stage count n:
  - n = min(norm_n, LIMIT), where LIMIT=LANES for SCALE/NORM and LIMIT=LANES/2 for PAIR.
  - mode=3: mode_err_o is set and the load runs as SCALE.
- FSM: IDLE -> RUN on accept with n>0; IDLE -> DONE on accept with n=0; RUN -> DONE after pair n-1; DONE -> IDLE after one non-stalled cycle.
- Latency: first pair is valid at cycle t+1. Pair s appears at t+1+s plus stall cycles.
- Pair s contents:
  - SCALE: op1 = lane[s]; op2 = scale.
  - PAIR: op1 = lane[2s]; op2 = lane[2s+1].
  - NORM: op1 = lane[s] >>> pos (arithmetic); op2 = lane[s] & ((1<<pos)-1) (remainder, zero-extended).
- out_valid_o=1 and stage_o=s for each pair. stage_boundary_o=1 only with pair n-1.
- out_valid_o=0 in IDLE and DONE. operand1_o, operand2_o and stage_o hold their last values when not valid.
- finished_o=1 for exactly the DONE cycle. For n=0 this is cycle t+1, with no pairs emitted.
- stall_i=1 freezes all of the following:
  - state and counters
  - all outputs, which hold their values (out_valid_o, finished_o and stage_boundary_o stay asserted if already asserted)
  - ready_o, which is forced low
- Stall during reset has no effect; reset dominates.
- mode_err_o clears only on reset.
- valid_i is ignored while busy.

Decomposition:
- Shared package pipe_stage_pkg:
  - mode enum (MODE_SCALE, MODE_PAIR, MODE_NORM, MODE_RSVD)
  - FSM state enum (ST_IDLE, ST_RUN, ST_DONE)
  - function returning LIMIT per mode
- One sub-module, pipe_pair_sel: combinational lane/mode/pos select that produces the next op1/op2. The parent registers its outputs.

Test Plan:
- Reset then SCALE with DATA_W=16, LANES=8, lanes 1..8, scale=0x0003, norm_n=8 -> pairs (1,3)..(8,3) on cycles t+1..t+8; stage_boundary_o at t+8; finished_o at t+9; ready_o back at t+10.
- PAIR with lanes 1..8, norm_n=7 -> clamped n=4; pairs (1,2),(3,4),(5,6),(7,8); stage_o 0..3.
- NORM with lane0=0xFF85 (-123), pos=4, norm_n=1 -> op1=0xFFF8, op2=0x0005, with stage_boundary_o on the same cycle.
- stall_i high for 3 cycles after pair 2 of a SCALE n=4 run -> pair 2 outputs held for 3 extra cycles, pair 3 follows, finished_o delayed by 3 cycles; valid_i pulses during the run are ignored.
- norm_n=0 -> no out_valid_o; finished_o at t+1. mode=3 load -> mode_err_o=1, SCALE pairs emitted, mode_err_o still 1 after the next clean load.
- RST_i low mid-run (after pair 1) -> all outputs 0 immediately (asynchronously); no finished_o; IDLE with ready_o=1 after release.
